// File: rtl/lob_pkg.sv
// Shared limit-order-book definitions: packed order word layout, sentinel words,
// command status codes and side encoding.
package lob_pkg;

   localparam int WORD_W   = 48;
   localparam int ID_HI    = 47;
   localparam int ID_LO    = 32;
   localparam int SIZE_HI  = 31;
   localparam int SIZE_LO  = 16;
   localparam int PRICE_HI = 15;
   localparam int PRICE_LO = 0;

   localparam logic [WORD_W-1:0] EMPTY_WORD   = 48'h0000_0000_0000;
   localparam logic [WORD_W-1:0] DELETED_WORD = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_FULL = 2'b01,
      ST_DUP  = 2'b10,
      ST_BAD  = 2'b11
   } status_e;

   typedef enum logic {
      SIDE_BUY  = 1'b0,
      SIDE_SELL = 1'b1
   } side_e;

   function automatic logic [WORD_W-1:0] pack_order(input logic [15:0] id,
                                                    input logic [15:0] size,
                                                    input logic [15:0] price);
      return {id, size, price};
   endfunction

   // Ids 0000/FFFF would alias the empty and deleted sentinels; size 0 is meaningless.
   function automatic logic args_legal(input logic [15:0] id, input logic [15:0] size);
      return (id != 16'h0000) && (id != 16'hFFFF) && (size != 16'h0000);
   endfunction

endpackage

// File: rtl/add_order_if.sv
// Command handshake plus order-RAM port bundle for the add-order engine.
interface add_order_if #(parameter int ADDR_W = 12);

   logic              start;
   logic              side;
   logic [15:0]       id;
   logic [15:0]       size;
   logic [15:0]       price;
   logic              done;
   logic [1:0]        status;
   logic [ADDR_W-1:0] slot;
   logic [ADDR_W-1:0] ram_addr;
   logic [47:0]       ram_wdata;
   logic              buy_we;
   logic              sell_we;
   logic [47:0]       buy_rdata;
   logic [47:0]       sell_rdata;

   modport master (
      output start, side, id, size, price, buy_rdata, sell_rdata,
      input  done, status, slot, ram_addr, ram_wdata, buy_we, sell_we
   );

   modport slave (
      input  start, side, id, size, price, buy_rdata, sell_rdata,
      output done, status, slot, ram_addr, ram_wdata, buy_we, sell_we
   );

endinterface

// File: rtl/add_order.sv
// Inserts an order into the buy or sell RAM: one scan for duplicates and the first
// reusable slot, then a single-cycle write of the packed word.
module add_order
   import lob_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int BOOK_DEPTH = 10
) (
   input  logic       clk,
   input  logic       rst,
   add_order_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_CHECK = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BOOK_DEPTH - 1);
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(0);

   state_e            state_r;
   side_e             side_r;
   logic [15:0]       id_r;
   logic [15:0]       size_r;
   logic [15:0]       price_r;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] slot_r;
   logic              found_r;
   logic              done_r;
   status_e           status_r;
   logic [ADDR_W-1:0] slot_out_r;

   logic [WORD_W-1:0] rd_s;
   logic              is_empty_s;
   logic              is_deleted_s;
   logic              is_dup_s;
   logic              last_s;
   logic [ADDR_W-1:0] ram_addr_s;

   // Decode of the word read back from the latched side during CHECK.
   always_comb begin
      rd_s = bus.buy_rdata;
      if (side_r == SIDE_SELL) begin
         rd_s = bus.sell_rdata;
      end else begin
         rd_s = bus.buy_rdata;
      end
      is_empty_s   = (rd_s == EMPTY_WORD);
      is_deleted_s = (rd_s == DELETED_WORD);
      is_dup_s     = (rd_s[ID_HI:ID_LO] == id_r) && !is_deleted_s;
      last_s       = (idx_r == LAST_IDX);
   end

   // Shared RAM address: the chosen slot while writing, the scan index otherwise.
   always_comb begin
      ram_addr_s = idx_r;
      if (state_r == S_WRITE) begin
         ram_addr_s = slot_r;
      end else begin
         ram_addr_s = idx_r;
      end
   end

   assign bus.ram_addr  = ram_addr_s;
   assign bus.ram_wdata = pack_order(id_r, size_r, price_r);
   assign bus.buy_we    = (state_r == S_WRITE) && (side_r == SIDE_BUY);
   assign bus.sell_we   = (state_r == S_WRITE) && (side_r == SIDE_SELL);
   assign bus.done      = done_r;
   assign bus.status    = status_r;
   assign bus.slot      = slot_out_r;

   // Command FSM and scan datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_IDLE;
         side_r     <= SIDE_BUY;
         id_r       <= 16'h0000;
         size_r     <= 16'h0000;
         price_r    <= 16'h0000;
         idx_r      <= ZERO_IDX;
         slot_r     <= ZERO_IDX;
         found_r    <= 1'b0;
         done_r     <= 1'b0;
         status_r   <= ST_OK;
         slot_out_r <= ZERO_IDX;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  side_r     <= side_e'(bus.side);
                  id_r       <= bus.id;
                  size_r     <= bus.size;
                  price_r    <= bus.price;
                  idx_r      <= ZERO_IDX;
                  slot_r     <= ZERO_IDX;
                  found_r    <= 1'b0;
                  slot_out_r <= ZERO_IDX;
                  if (!args_legal(bus.id, bus.size)) begin
                     status_r <= ST_BAD;
                     done_r   <= 1'b1;
                     state_r  <= S_DONE;
                  end else begin
                     state_r  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               state_r <= S_CHECK;
            end
            S_CHECK: begin
               if (is_empty_s) begin
                  // Nothing is ever stored past the first empty word.
                  if (!found_r) begin
                     slot_r <= idx_r;
                  end
                  state_r <= S_WRITE;
               end else if (is_dup_s) begin
                  status_r <= ST_DUP;
                  done_r   <= 1'b1;
                  state_r  <= S_DONE;
               end else begin
                  if (is_deleted_s && !found_r) begin
                     slot_r  <= idx_r;
                     found_r <= 1'b1;
                  end
                  if (last_s) begin
                     // A deleted word in the final slot counts as found this cycle.
                     if (found_r || is_deleted_s) begin
                        state_r <= S_WRITE;
                     end else begin
                        status_r <= ST_FULL;
                        done_r   <= 1'b1;
                        state_r  <= S_DONE;
                     end
                  end else begin
                     idx_r   <= idx_r + ONE_IDX;
                     state_r <= S_FETCH;
                  end
               end
            end
            S_WRITE: begin
               status_r   <= ST_OK;
               slot_out_r <= slot_r;
               done_r     <= 1'b1;
               state_r    <= S_DONE;
            end
            S_DONE: begin
               if (!bus.start) begin
                  done_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_order.sv
// Self-checking bench for add_order: RAM models on both sides, directed scenarios and
// randomized books checked against a slot-by-slot reference of the insertion rules.
module tb_add_order;

   localparam int DEPTH = 10;
   localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   add_order_if #(.ADDR_W(12)) bus ();

   add_order #(.ADDR_W(12), .BOOK_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [47:0] buy_mem [16];
   logic [47:0] sell_mem[16];
   logic [47:0] buy_img [16];
   logic [47:0] sell_img[16];
   logic        ld_req;
   logic [47:0] buy_q;
   logic [47:0] sell_q;
   int          buy_wr;
   int          sell_wr;
   logic [11:0] wr_addr;
   logic [47:0] wr_data;

   // RAM macros: registered address, one-cycle read latency, image load from the bench.
   always @(posedge clk) begin
      if (ld_req) begin
         buy_mem  <= buy_img;
         sell_mem <= sell_img;
      end else begin
         if (bus.buy_we)  buy_mem[bus.ram_addr[3:0]]  <= bus.ram_wdata;
         if (bus.sell_we) sell_mem[bus.ram_addr[3:0]] <= bus.ram_wdata;
      end
      buy_q  <= buy_mem[bus.ram_addr[3:0]];
      sell_q <= sell_mem[bus.ram_addr[3:0]];
   end

   assign bus.buy_rdata  = buy_q;
   assign bus.sell_rdata = sell_q;

   // Write monitor.
   always @(negedge clk) begin
      if (bus.buy_we || bus.sell_we) begin
         wr_addr <= bus.ram_addr;
         wr_data <= bus.ram_wdata;
      end
      if (bus.buy_we)  buy_wr  <= buy_wr + 1;
      if (bus.sell_we) sell_wr <= sell_wr + 1;
   end

   task automatic load_rams();
      @(negedge clk); ld_req = 1'b1;
      @(negedge clk); ld_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_imgs();
      for (int k = 0; k < 16; k++) begin
         buy_img[k]  = 48'h0;
         sell_img[k] = 48'h0;
      end
   endtask

   // Reference: walk the book as a list of words and apply the insertion rules.
   function automatic void model(input logic s, input logic [15:0] i, input logic [15:0] sz,
                                 output logic [1:0] st, output int sl, output int cyc, output int nwr);
      logic [47:0] w;
      bit found;
      bit exited;
      int fs;
      found = 0; exited = 0; fs = 0;
      st = 2'b01; sl = 0; nwr = 0; cyc = 1 + 2 * DEPTH;
      if (i == 16'h0000 || i == 16'hFFFF || sz == 16'h0000) begin
         st = 2'b11; cyc = 1;
         return;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (!exited) begin
            w = s ? sell_img[k] : buy_img[k];
            if (w == 48'h0) begin
               st = 2'b00; sl = found ? fs : k; nwr = 1; cyc = 2 * (k + 1) + 2; exited = 1;
            end else if (w[47:32] == i && w != ONES) begin
               st = 2'b10; cyc = 2 * (k + 1) + 1; exited = 1;
            end else if (w == ONES && !found) begin
               found = 1; fs = k;
            end
         end
      end
      if (!exited && found) begin
         st = 2'b00; sl = fs; nwr = 1; cyc = 2 * DEPTH + 2;
      end
   endfunction

   // Raise start with the given arguments and wait (bounded) for done.
   task automatic run_op(input logic s, input logic [15:0] i, input logic [15:0] sz,
                         input logic [15:0] pr, output int cyc, output int nb, output int ns);
      int b0;
      int s0;
      @(negedge clk);
      b0 = buy_wr; s0 = sell_wr;
      bus.side = s; bus.id = i; bus.size = sz; bus.price = pr; bus.start = 1'b1;
      cyc = 0;
      while (!bus.done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         // Later input changes must be ignored.
         bus.id = 16'($urandom); bus.side = 1'($urandom);
      end
      nb = buy_wr - b0;
      ns = sell_wr - s0;
   endtask

   task automatic drop_start();
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      total++; if (bus.status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", bus.status); end
      total++; if (bus.slot !== 12'h0 || bus.ram_addr !== 12'h0) begin bad++; $display("FAIL reset_addr slot=%h addr=%h exp=0", bus.slot, bus.ram_addr); end
      total++; if (bus.buy_we !== 1'b0 || bus.sell_we !== 1'b0 || bus.ram_wdata !== 48'h0) begin bad++; $display("FAIL reset_we we=%b%b wdata=%h exp=0", bus.buy_we, bus.sell_we, bus.ram_wdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_empty_buy();
      int cyc, nb, ns;
      clear_imgs(); load_rams();
      run_op(1'b0, 16'd5, 16'd100, 16'd2000, cyc, nb, ns);
      total++; if (cyc != 4) begin bad++; $display("FAIL empty_latency got=%0d exp=4", cyc); end
      total++; if (bus.status !== 2'b00 || bus.slot !== 12'd0) begin bad++; $display("FAIL empty_result status=%b slot=%0d exp=00/0", bus.status, bus.slot); end
      total++; if (nb != 1 || ns != 0) begin bad++; $display("FAIL empty_we buy=%0d sell=%0d exp=1/0", nb, ns); end
      total++; if (wr_addr !== 12'd0 || wr_data !== 48'h0005_0064_07D0) begin bad++; $display("FAIL empty_word addr=%0d data=%h exp=0/000500640 7d0", wr_addr, wr_data); end
      drop_start();
   endtask

   task automatic test_deleted_reuse();
      int cyc, nb, ns;
      clear_imgs();
      sell_img[0] = 48'h0003_0001_0001; sell_img[1] = ONES; sell_img[2] = 48'h0004_0001_0001;
      load_rams();
      run_op(1'b1, 16'd9, 16'd7, 16'd300, cyc, nb, ns);
      total++; if (cyc != 10) begin bad++; $display("FAIL reuse_latency got=%0d exp=10", cyc); end
      total++; if (bus.status !== 2'b00 || bus.slot !== 12'd1) begin bad++; $display("FAIL reuse_result status=%b slot=%0d exp=00/1", bus.status, bus.slot); end
      total++; if (nb != 0 || ns != 1 || wr_addr !== 12'd1 || wr_data !== 48'h0009_0007_012C) begin bad++; $display("FAIL reuse_write buy=%0d sell=%0d addr=%0d data=%h exp=0/1/1/00090007012c", nb, ns, wr_addr, wr_data); end
      drop_start();
   endtask

   task automatic test_dup_past_free();
      int cyc, nb, ns;
      clear_imgs();
      buy_img[0] = 48'h0007_0001_0001; buy_img[1] = ONES; buy_img[2] = 48'h0005_0002_0002;
      load_rams();
      run_op(1'b0, 16'd5, 16'd1, 16'd1, cyc, nb, ns);
      total++; if (cyc != 7 || bus.status !== 2'b10) begin bad++; $display("FAIL dup cyc=%0d status=%b exp=7/10", cyc, bus.status); end
      total++; if (nb != 0 || ns != 0 || bus.slot !== 12'd0) begin bad++; $display("FAIL dup_nowrite buy=%0d sell=%0d slot=%0d exp=0/0/0", nb, ns, bus.slot); end
      drop_start();
   endtask

   task automatic test_full();
      int cyc, nb, ns;
      clear_imgs();
      for (int k = 0; k < DEPTH; k++) buy_img[k] = {16'(k + 11), 16'd1, 16'd1};
      load_rams();
      run_op(1'b0, 16'd8, 16'd1, 16'd1, cyc, nb, ns);
      total++; if (cyc != 21 || bus.status !== 2'b01) begin bad++; $display("FAIL full cyc=%0d status=%b exp=21/01", cyc, bus.status); end
      total++; if (nb != 0 || ns != 0) begin bad++; $display("FAIL full_nowrite buy=%0d sell=%0d exp=0/0", nb, ns); end
      drop_start();
   endtask

   task automatic test_bad_args();
      int cyc, nb, ns;
      logic [15:0] ids[3];
      logic [15:0] szs[3];
      ids = '{16'd5, 16'hFFFF, 16'h0000};
      szs = '{16'd0, 16'd10, 16'd10};
      clear_imgs(); load_rams();
      for (int t = 0; t < 3; t++) begin
         run_op(1'b0, ids[t], szs[t], 16'd1, cyc, nb, ns);
         total++; if (cyc != 1 || bus.status !== 2'b11 || nb != 0 || ns != 0) begin bad++; $display("FAIL bad_args%0d cyc=%0d status=%b writes=%0d exp=1/11/0", t, cyc, bus.status, nb + ns); end
         drop_start();
      end
   endtask

   task automatic test_hold_and_reset();
      int cyc, nb, ns, b0, held;
      clear_imgs(); load_rams();
      run_op(1'b0, 16'd5, 16'd100, 16'd2000, cyc, nb, ns);
      b0 = buy_wr; held = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) held++;
      end
      total++; if (held != 6 || buy_wr != b0) begin bad++; $display("FAIL hold done_cycles=%0d extra_writes=%0d exp=6/0", held, buy_wr - b0); end
      bus.start = 1'b0;
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL release done=%b exp=0", bus.done); end
      // Abort a scan with reset, then repeat the basic insertion.
      for (int k = 0; k < DEPTH; k++) buy_img[k] = {16'(k + 11), 16'd1, 16'd1};
      load_rams();
      bus.side = 1'b0; bus.id = 16'd8; bus.size = 16'd1; bus.price = 16'd1; bus.start = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (bus.done !== 1'b0 || bus.buy_we !== 1'b0 || bus.sell_we !== 1'b0 || bus.ram_addr !== 12'd0) begin bad++; $display("FAIL midreset done=%b we=%b%b addr=%0d exp=0/00/0", bus.done, bus.buy_we, bus.sell_we, bus.ram_addr); end
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      clear_imgs(); load_rams();
      run_op(1'b0, 16'd5, 16'd100, 16'd2000, cyc, nb, ns);
      total++; if (cyc != 4 || bus.status !== 2'b00 || bus.slot !== 12'd0 || nb != 1 || wr_data !== 48'h0005_0064_07D0) begin bad++; $display("FAIL after_reset cyc=%0d status=%b slot=%0d writes=%0d data=%h exp=4/00/0/1/0005006407d0", cyc, bus.status, bus.slot, nb, wr_data); end
      drop_start();
   endtask

   task automatic test_random();
      int cyc, nb, ns, e_sl, e_cyc, e_nwr, r;
      logic [1:0]  e_st;
      logic        s;
      logic [15:0] i, sz, pr;
      for (int n = 0; n < 40; n++) begin
         clear_imgs();
         for (int k = 0; k < DEPTH; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      buy_img[k] = 48'h0;
            else if (r < 4) buy_img[k] = ONES;
            else            buy_img[k] = {16'($urandom_range(1, 6)), 16'($urandom), 16'($urandom)};
            r = int'($urandom_range(0, 9));
            if (r < 2)      sell_img[k] = 48'h0;
            else if (r < 4) sell_img[k] = ONES;
            else            sell_img[k] = {16'($urandom_range(1, 6)), 16'($urandom), 16'($urandom)};
         end
         load_rams();
         s  = 1'($urandom);
         i  = 16'($urandom_range(1, 7));
         sz = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
         pr = 16'($urandom);
         model(s, i, sz, e_st, e_sl, e_cyc, e_nwr);
         run_op(s, i, sz, pr, cyc, nb, ns);
         total++; if (cyc != e_cyc || bus.status !== e_st) begin bad++; $display("FAIL rand%0d_result cyc=%0d status=%b exp=%0d/%b", n, cyc, bus.status, e_cyc, e_st); end
         total++; if (int'(bus.slot) != e_sl) begin bad++; $display("FAIL rand%0d_slot got=%0d exp=%0d", n, bus.slot, e_sl); end
         total++; if ((s ? ns : nb) != e_nwr || (s ? nb : ns) != 0) begin bad++; $display("FAIL rand%0d_we buy=%0d sell=%0d exp_side_writes=%0d", n, nb, ns, e_nwr); end
         if (e_nwr == 1) begin
            total++; if (int'(wr_addr) != e_sl || wr_data !== {i, sz, pr}) begin bad++; $display("FAIL rand%0d_word addr=%0d data=%h exp=%0d/%h", n, wr_addr, wr_data, e_sl, {i, sz, pr}); end
         end
         drop_start();
      end
   endtask

   initial begin
      total = 0; bad = 0;
      buy_wr = 0; sell_wr = 0;
      ld_req = 1'b0;
      bus.start = 1'b0; bus.side = 1'b0; bus.id = 16'h0; bus.size = 16'h0; bus.price = 16'h0;
      test_reset();
      test_empty_buy();
      test_deleted_reuse();
      test_dup_past_free();
      test_full();
      test_bad_args();
      test_hold_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
